// File: rtl/nes_pad_responder.sv
// Device-side NES pad responder: samples a button word on latch and shifts it out
// one bit per host pad clock rising edge, emulating a 4021-based gamepad.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        latch,
    input  logic        pad_clk,
    input  logic [7:0]  buttons,
    output logic        data,
    output logic        frame_done,
    output logic [3:0]  bit_idx,
    output logic [15:0] poll_count
);

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BTN_W   = 8;
    localparam int unsigned SEL_W   = 3;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BTN_W - 1);
    localparam logic [IDX_W-1:0] IDX_EXHAUSTED = IDX_W'(BTN_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] latch_sync;
    logic [SYNC_STAGES-1:0] pad_sync;
    logic                   latch_dly;
    logic                   pad_dly;

    logic             latch_s;
    logic             latch_fall;
    logic             pad_rise;

    logic [BTN_W-1:0] snap, snap_n;
    logic             data_n;
    logic             done_n;
    logic [IDX_W-1:0] bit_idx_n;
    logic [IDX_W-1:0] bit_inc;
    logic [SEL_W-1:0] shift_sel;
    logic [CNT_W-1:0] count_n;

    // Input synchronizers plus one delay flop each for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_sync <= '0;
            pad_sync   <= '0;
            latch_dly  <= 1'b0;
            pad_dly    <= 1'b0;
        end else begin
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
            pad_sync   <= {pad_sync[SYNC_STAGES-2:0], pad_clk};
            latch_dly  <= latch_sync[SYNC_STAGES-1];
            pad_dly    <= pad_sync[SYNC_STAGES-1];
        end
    end

    assign latch_s    = latch_sync[SYNC_STAGES-1];
    assign latch_fall = latch_dly & ~latch_s;
    assign pad_rise   = pad_sync[SYNC_STAGES-1] & ~pad_dly;

    assign bit_inc   = bit_idx + IDX_W'(1);
    assign shift_sel = SEL_W'(IDX_LAST - bit_inc);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= 8'hFF;
            data       <= 1'b1;
            frame_done <= 1'b0;
            bit_idx    <= IDX_EXHAUSTED;
            poll_count <= '0;
        end else begin
            state      <= state_n;
            snap       <= snap_n;
            data       <= data_n;
            frame_done <= done_n;
            bit_idx    <= bit_idx_n;
            poll_count <= count_n;
        end
    end

    // Next state and next output values; latch level overrides everything,
    // so a simultaneous pad clock edge is simply dropped.
    always_comb begin
        state_n   = state;
        snap_n    = snap;
        data_n    = data;
        done_n    = 1'b0;
        bit_idx_n = bit_idx;
        count_n   = poll_count;

        if (latch_s) begin
            state_n   = LOAD;
            snap_n    = buttons;
            data_n    = buttons[BTN_W-1];
            bit_idx_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    data_n    = 1'b1;
                    bit_idx_n = IDX_EXHAUSTED;
                end
                LOAD: begin
                    snap_n    = buttons;
                    data_n    = buttons[BTN_W-1];
                    bit_idx_n = '0;
                    if (latch_fall) begin
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pad_rise) begin
                        if (bit_idx >= IDX_LAST) begin
                            state_n   = DONE;
                            data_n    = 1'b1;
                            bit_idx_n = IDX_EXHAUSTED;
                            done_n    = 1'b1;
                            count_n   = poll_count + CNT_W'(1);
                        end else begin
                            data_n    = snap[shift_sel];
                            bit_idx_n = bit_inc;
                        end
                    end
                end
                DONE: begin
                    data_n    = 1'b1;
                    bit_idx_n = IDX_EXHAUSTED;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Self-checking bench for nes_pad_responder: a host-level model plays the NES reader
// and predicts the serial stream, frame pulses and poll count from the button words.
module tb_nes_pad_responder;

    localparam int unsigned SYNC = 2;
    localparam int unsigned LAT  = SYNC + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        latch;
    logic        pad_clk;
    logic [7:0]  buttons;
    logic        data;
    logic        frame_done;
    logic [3:0]  bit_idx;
    logic [15:0] poll_count;

    int compared   = 0;
    int mismatched = 0;
    int fd_cnt     = 0;
    int hp         = 6;
    int frames_exp = 0;

    nes_pad_responder #(.SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst       (rst),
        .latch     (latch),
        .pad_clk   (pad_clk),
        .buttons   (buttons),
        .data      (data),
        .frame_done(frame_done),
        .bit_idx   (bit_idx),
        .poll_count(poll_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse counter; a frame_done pulse must coincide with data back at idle high
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt++;
            check("done_with_data_high", 16'(data), 16'd1);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch_pulse(input logic [7:0] b);
        buttons = b;
        latch   = 1'b1;
        wait_cyc(hp);
        check("load_bit_idx", 16'(bit_idx), 16'd0);
        check("load_data", 16'(data), 16'(b[7]));
        latch = 1'b0;
        wait_cyc(hp);
    endtask

    // Host reads n bits starting at position first; beyond bit 7 the line idles high
    task automatic shift_bits(input logic [7:0] snapv, input int n, input int first,
                              output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < n; i++) begin
            int k;
            logic expb;
            k    = first + i;
            expb = (k < 8) ? snapv[7 - k] : 1'b1;
            check("serial_bit", 16'(data), 16'(expb));
            if (k < 8) got[7 - k] = data;
            pad_clk = 1'b1;
            wait_cyc(LAT);
            check("bit_idx_after_rise", 16'(bit_idx), 16'((k + 1 < 8) ? k + 1 : 8));
            wait_cyc(hp - LAT);
            pad_clk = 1'b0;
            wait_cyc(hp);
        end
    endtask

    task automatic frame_end(input int fd_before, input int pulses);
        check("end_data", 16'(data), 16'd1);
        check("end_bit_idx", 16'(bit_idx), 16'd8);
        check("frame_done_pulses", 16'(fd_cnt - fd_before), 16'(pulses));
        check("poll_count", poll_count, 16'(frames_exp));
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] r;
        int fd0;

        rst = 1'b1; latch = 1'b0; pad_clk = 1'b0; buttons = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            latch   = ~latch;
            pad_clk = ~pad_clk;
            wait_cyc(1);
        end
        latch = 1'b0; pad_clk = 1'b0;
        check("reset_frame_done", 16'(frame_done), 16'd0);
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(LAT);
        check("reset_data", 16'(data), 16'd1);
        check("reset_bit_idx", 16'(bit_idx), 16'd8);
        check("reset_poll_count", poll_count, 16'd0);
        check("reset_no_pulse", 16'(fd_cnt), 16'd0);

        // Full frame, then buttons cleared after latch (snapshot must hold)
        fd0 = fd_cnt;
        latch_pulse(8'b0111_1110);
        buttons = 8'h00;
        shift_bits(8'b0111_1110, 8, 0, got);
        frames_exp++;
        frame_end(fd0, 1);
        check("frame_word", 16'(got), 16'h7E);

        // Abort after three bits; new frame with 0xAA
        fd0 = fd_cnt;
        latch_pulse(8'h3C);
        shift_bits(8'h3C, 3, 0, got);
        buttons = 8'hAA;
        latch   = 1'b1;
        wait_cyc(hp);
        check("abort_bit_idx", 16'(bit_idx), 16'd0);
        check("abort_data", 16'(data), 16'd1);
        latch = 1'b0;
        wait_cyc(hp);
        check("abort_no_pulse", 16'(fd_cnt - fd0), 16'd0);
        check("abort_no_count", poll_count, 16'(frames_exp));
        shift_bits(8'hAA, 8, 0, got);
        frames_exp++;
        frame_end(fd0, 1);

        // Over-clocking: 12 rises, only one pulse and one count
        fd0 = fd_cnt;
        latch_pulse(8'h5A);
        shift_bits(8'h5A, 12, 0, got);
        frames_exp++;
        frame_end(fd0, 1);

        // Latch rise and pad rise together mid-frame: latch wins
        fd0 = fd_cnt;
        latch_pulse(8'h5C);
        shift_bits(8'h5C, 2, 0, got);
        buttons = 8'h33;
        latch   = 1'b1;
        pad_clk = 1'b1;
        wait_cyc(hp);
        check("collide_bit_idx", 16'(bit_idx), 16'd0);
        check("collide_data", 16'(data), 16'd0);
        latch = 1'b0;
        wait_cyc(hp);
        pad_clk = 1'b0;
        wait_cyc(hp);
        check("collide_bit_idx_hold", 16'(bit_idx), 16'd0);
        shift_bits(8'h33, 8, 0, got);
        frames_exp++;
        frame_end(fd0, 1);

        // Reset mid-frame aborts; later pad clocks without latch do nothing
        latch_pulse(8'hC3);
        shift_bits(8'hC3, 3, 0, got);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        frames_exp = 0;
        fd0 = fd_cnt;
        check("midreset_data", 16'(data), 16'd1);
        check("midreset_bit_idx", 16'(bit_idx), 16'd8);
        check("midreset_poll_count", poll_count, 16'd0);
        for (int i = 0; i < 3; i++) begin
            pad_clk = 1'b1; wait_cyc(hp);
            pad_clk = 1'b0; wait_cyc(hp);
        end
        check("idle_clocks_data", 16'(data), 16'd1);
        check("idle_clocks_bit_idx", 16'(bit_idx), 16'd8);
        check("idle_clocks_no_pulse", 16'(fd_cnt - fd0), 16'd0);

        // Host loopback sweep of all 256 words at minimum legal timing,
        // with random button noise while shifting
        hp = LAT;
        r  = 8'($urandom);
        for (int v = 0; v < 256; v++) begin
            logic [7:0] w;
            w   = 8'(v) ^ r;
            fd0 = fd_cnt;
            latch_pulse(w);
            buttons = 8'($urandom);
            shift_bits(w, 8, 0, got);
            frames_exp++;
            check("loopback_word", 16'(got), 16'(w));
            check("loopback_pulse", 16'(fd_cnt - fd0), 16'd1);
        end
        check("loopback_poll_count", poll_count, 16'(frames_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
